// File: rtl/pc_unit_pkg.sv
// Shared types and default vectors for the program counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEL_TRAP,
        PC_SEL_REDIRECT,
        PC_SEL_RAS,
        PC_SEL_SEQ,
        PC_SEL_HOLD
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_unit_if.sv
// Control/execute <-> PC unit bus; master drives the control inputs, slave is the PC unit.
interface pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            pc_write;
    logic            trap;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_inc;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_underflow;
    logic            misaligned;

    modport master (
        output pc_write, trap, redirect_valid, redirect_target, is_call, is_ret,
        input  pc, pc_plus_inc, ras_empty, ras_full, ras_underflow, misaligned
    );

    modport slave (
        input  pc_write, trap, redirect_valid, redirect_target, is_call, is_ret,
        output pc, pc_plus_inc, ras_empty, ras_full, ras_underflow, misaligned
    );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_eff;
    logic [PTR_W-1:0] wr_ptr;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(RAS_DEPTH));
    assign top_data = mem[top_ptr];
    assign pop_eff  = pop && !empty;
    // Pop+push replaces the top slot in place; a plain push goes one slot up.
    assign wr_ptr   = pop_eff ? top_ptr : top_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push && !pop_eff) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (pop_eff && !push) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: prioritised next-PC select, alignment masking and return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input logic        clk,
    input logic        rst,
    pc_unit_if.slave   bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] next_raw;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic            underflow_q;
    logic            misaligned_q;
    logic            ras_push;
    logic            ras_pop;
    pc_sel_e         sel;

    assign pc_inc = pc_q + XLEN'(INC);

    always_comb begin
        sel = PC_SEL_HOLD;
        if (bus.pc_write) begin
            if (bus.trap)                          sel = PC_SEL_TRAP;
            else if (bus.redirect_valid)           sel = PC_SEL_REDIRECT;
            else if (bus.is_ret && !ras_empty)     sel = PC_SEL_RAS;
            else                                   sel = PC_SEL_SEQ;
        end
    end

    always_comb begin
        next_raw = pc_q;
        unique case (sel)
            PC_SEL_TRAP:     next_raw = TRAP_VECTOR;
            PC_SEL_REDIRECT: next_raw = bus.redirect_target;
            PC_SEL_RAS:      next_raw = ras_top;
            PC_SEL_SEQ:      next_raw = pc_inc;
            default:         next_raw = pc_q;
        endcase
    end

    // A return still pops when a redirect wins the select, keeping the stack in step.
    assign ras_push = bus.pc_write && !bus.trap && bus.is_call;
    assign ras_pop  = bus.pc_write && !bus.trap && bus.is_ret;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            underflow_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= next_raw & ~ALIGN_MASK;
            underflow_q  <= (sel == PC_SEL_SEQ) && bus.is_ret;
            misaligned_q <= (sel != PC_SEL_HOLD) && ((next_raw & ALIGN_MASK) != '0);
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus_inc   = pc_inc;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_underflow = underflow_q;
    assign bus.misaligned    = misaligned_q;
endmodule
